// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Latency: the word read at PC appears on IF/ID one clock edge later; PC has no input-to-output combinational path.
// Backpressure: Stall holds PC and IF/ID; Flush bubbles IF/ID. Optional trap support is built when FETCH_EXCEPTION_EN is defined.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] JumpRegister,
  input  logic [31:0] Instruction,
`ifdef FETCH_EXCEPTION_EN
  input  logic        Exception,
  output logic [31:0] EPC,
`endif
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_JMP  = 2'b10;
  localparam logic [1:0] SRC_JR   = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

`ifdef FETCH_EXCEPTION_EN
  logic [31:0] epc_q, epc_d;
`endif

  // Sequential address and redirect target selection; targets are word-aligned.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    next_pc  = pc_plus4;
    case (PCSrc)
      SRC_SEQ: next_pc = pc_plus4;
      SRC_BR:  next_pc = {BranchTarget[31:2], 2'b00};
      SRC_JMP: next_pc = {ifid_pcp4_q[31:28], JumpIndex, 2'b00};
      SRC_JR:  next_pc = {JumpRegister[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  // Next-state for PC and IF/ID: trap > flush (IF/ID only) > stall > normal advance.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_vld_d   = ifid_vld_q;
`ifdef FETCH_EXCEPTION_EN
    epc_d        = epc_q;
    if (Exception) begin
      // Trap redirects unconditionally; EPC is the address of the instruction in IF/ID.
      pc_d         = EXC_VECTOR;
      epc_d        = ifid_pcp4_q - 32'd4;
      ifid_instr_d = 32'd0;
      ifid_pcp4_d  = 32'd0;
      ifid_vld_d   = 1'b0;
    end else
`endif
    begin
      if (Flush) begin
        ifid_instr_d = 32'd0;
        ifid_pcp4_d  = 32'd0;
        ifid_vld_d   = 1'b0;
      end else if (!Stall) begin
        ifid_instr_d = Instruction;
        ifid_pcp4_d  = pc_plus4;
        ifid_vld_d   = 1'b1;
      end
      // A flush does not stop the PC; redirect and squash share the same edge.
      if (!Stall) begin
        pc_d = next_pc;
      end
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= 32'd0;
      ifid_instr_q <= 32'd0;
      ifid_pcp4_q  <= 32'd0;
      ifid_vld_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

`ifdef FETCH_EXCEPTION_EN
  // Exception PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q <= 32'd0;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign EPC = epc_q;
`endif

  assign PC                = pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_PCPlus4     = ifid_pcp4_q;
  assign IF_ID_Valid       = ifid_vld_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- Stall  input  1  hold PC and IF/ID contents.
- Flush  input  1  replace next IF/ID entry with bubble.
- PCSrc  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- BranchTarget  input  32  absolute branch target.
- JumpIndex  input  26  J-type index field.
- JumpRegister  input  32  register jump target.
- Instruction  input  32  combinational read data from instruction memory at PC.
- PC  output  32  fetch address driven to instruction memory.
- IF_ID_Instruction  output  32  registered instruction.
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
- IF_ID_Valid  output  1  entry holds a real instruction.

Function
REQ-002 SHALL update all state only on rising clk; no combinational path from any input to PC.
REQ-003 SHALL compute PCPlus4 = PC + 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-004 SHALL select NextPC by PCSrc:
- 00 -> PCPlus4.
- 01 -> BranchTarget with bits [1:0] forced to 00.
- 10 -> {IF_ID_PCPlus4[31:28], JumpIndex, 2'b00}.
- 11 -> JumpRegister with bits [1:0] forced to 00.
REQ-005 With Stall=0, SHALL load PC <= NextPC each edge.
REQ-006 With Stall=0 and Flush=0, SHALL load IF_ID_Instruction <= Instruction, IF_ID_PCPlus4 <= PCPlus4, IF_ID_Valid <= 1.
REQ-007 Latency: the word read at PC SHALL appear on IF_ID_Instruction exactly one edge later.
REQ-008 Stall=1 SHALL hold PC, IF_ID_Instruction, IF_ID_PCPlus4 and IF_ID_Valid, and SHALL ignore PCSrc.
REQ-009 Flush=1 SHALL load IF_ID_Instruction <= 0 (NOP), IF_ID_PCPlus4 <= 0 and IF_ID_Valid <= 0, regardless of Stall.
REQ-010 Flush=1 with Stall=0 SHALL still load PC <= NextPC, so redirect and squash happen on the same edge.
REQ-011 Flush=1 with Stall=1 SHALL hold PC and clear IF/ID.
REQ-012 Priority SHALL be: reset > exception (if compiled) > Flush (IF/ID only) > Stall > PCSrc.

Reset
REQ-013 reset=1 at an edge SHALL set PC=0x00000000, IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, overriding all other inputs.
REQ-014 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; first fetch after release SHALL be from address 0.

Configuration
REQ-015 Macro FETCH_EXCEPTION_EN, when defined, SHALL add:
- input Exception (1 bit).
- output EPC (32 bits), reset value 0.
REQ-016 With FETCH_EXCEPTION_EN defined, Exception=1 at an edge SHALL:
- set PC <= 0x80000180 and EPC <= IF_ID_PCPlus4 - 4.
- clear IF/ID as Flush does.
- override Stall and PCSrc.
REQ-017 Without FETCH_EXCEPTION_EN, the Exception and EPC ports SHALL NOT exist and behaviour SHALL match REQ-002..REQ-014 exactly.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then 4 edges with PCSrc=00, memory word n = 0x1000_0000+n -> PC 0,4,8,12,16; IF_ID_Instruction 0x10000000..0x10000003; IF_ID_PCPlus4 4,8,12,16.
- Stall=1 for 3 edges at PC=8 -> PC stays 8 and IF/ID unchanged; Stall=0 -> PC=12.
- PCSrc=01, BranchTarget=0x00000043, Flush=1 -> PC=0x40, IF_ID_Valid=0, IF_ID_Instruction=0.
- IF_ID_PCPlus4=0xA0000010, PCSrc=10, JumpIndex=0x0000040 -> PC=0xA0000100.
- PC forced to 0xFFFFFFFC, PCSrc=00 -> PC=0x00000000, IF_ID_PCPlus4=0.
- FETCH_EXCEPTION_EN defined, IF_ID_PCPlus4=0x24, Exception=1 with Stall=1 -> PC=0x80000180, EPC=0x20, IF_ID_Valid=0.
